// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath.
//   DEF_DATA_W / DEF_COEF_W / DEF_ACC_W : default pixel, coefficient and result widths
//   KERNEL_TAPS                         : taps in a 3x3 kernel
//   TAP_TL .. TAP_BR                    : tap indices, 0 = top-left (oldest), 8 = bottom-right (newest)
//   pixel_t / coef_t / acc_t            : types at the default widths
package cnn_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_COEF_W  = 8;
  localparam int unsigned DEF_ACC_W   = 21;
  localparam int unsigned KERNEL_TAPS = 9;

  localparam int unsigned TAP_TL = 0;
  localparam int unsigned TAP_TC = 1;
  localparam int unsigned TAP_TR = 2;
  localparam int unsigned TAP_ML = 3;
  localparam int unsigned TAP_MC = 4;
  localparam int unsigned TAP_MR = 5;
  localparam int unsigned TAP_BL = 6;
  localparam int unsigned TAP_BC = 7;
  localparam int unsigned TAP_BR = 8;

  typedef logic        [DEF_DATA_W-1:0] pixel_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/line_buffer.sv
// Line delay: shift register of DEPTH entries that advances only when en_i is high.
// dout_o is the value written DEPTH enabled cycles earlier. Contents are not reset;
// downstream logic qualifies them with its own valid tracking.
//   clock  : rising-edge clock
//   en_i   : shift enable
//   din_i  : data in  [WIDTH]
//   dout_o : data out [WIDTH]
module line_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clock) begin
    if (en_i) begin
      sr_q <= {sr_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster-order pixel stream.
// Two line delays feed a 3x3 window; one signed MAC result is produced per complete window,
// two clock edges after the window is loaded (product stage, then adder-tree stage).
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   pix_valid  : pixel accepted on each rising edge where high
//   pix_data   : unsigned pixel [DATA_W]
//   coef_we    : coefficient write strobe
//   coef_addr  : tap index 0..8 (9..15 ignored)
//   coef_data  : signed coefficient [COEF_W]
//   out_valid  : out_data valid
//   out_data   : signed result [ACC_W]
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv3x3_stream
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic        [DATA_W-1:0] pix_data,
  input  logic                     coef_we,
  input  logic        [3:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     frame_done
);

  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic [DATA_W-1:0]        win_q  [KERNEL_TAPS];
  logic signed [COEF_W-1:0] coef_q [KERNEL_TAPS];
  logic signed [PROD_W-1:0] prod_d [KERNEL_TAPS];
  logic signed [PROD_W-1:0] prod_q [KERNEL_TAPS];

  logic win_valid_q;
  logic prod_valid_q;
  logic out_valid_q;
  logic frame_done_q;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] res_d;
  logic signed [ACC_W-1:0] out_data_q;

  logic [DATA_W-1:0] lb1_out;
  logic [DATA_W-1:0] lb2_out;

  // lb1 yields the pixel one row above the incoming one, lb2 two rows above.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clock  (clock),
    .en_i   (pix_valid),
    .din_i  (pix_data),
    .dout_o (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
    .clock  (clock),
    .en_i   (pix_valid),
    .din_i  (lb1_out),
    .dout_o (lb2_out)
  );

  // Raster position of the pixel being offered on pix_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_valid) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Window shifts left; the right column is {two rows up, one row up, incoming pixel}.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
        win_q[t] <= '0;
      end
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= pix_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
      frame_done_q <= pix_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (pix_valid) begin
        win_q[TAP_TL] <= win_q[TAP_TC];
        win_q[TAP_TC] <= win_q[TAP_TR];
        win_q[TAP_TR] <= lb2_out;
        win_q[TAP_ML] <= win_q[TAP_MC];
        win_q[TAP_MC] <= win_q[TAP_MR];
        win_q[TAP_MR] <= lb1_out;
        win_q[TAP_BL] <= win_q[TAP_BC];
        win_q[TAP_BC] <= win_q[TAP_BR];
        win_q[TAP_BR] <= pix_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
        coef_q[t] <= '0;
      end
    end else if (coef_we && (coef_addr <= 4'(TAP_BR))) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Pixels are zero-extended by one bit so the multiply is a true signed product.
  always_comb begin
    for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
      prod_d[t] = $signed({1'b0, win_q[t]}) * coef_q[t];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
        prod_q[t] <= '0;
      end
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= win_valid_q;
      if (win_valid_q) begin
        for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
          prod_q[t] <= prod_d[t];
        end
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
      sum_d = sum_d + ACC_W'(prod_q[t]);
    end
  end

`ifdef CONV_RELU_EN
  assign res_d = sum_d[ACC_W-1] ? '0 : sum_d;
`else
  assign res_d = sum_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= prod_valid_q;
      if (prod_valid_q) begin
        out_data_q <= res_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream (8x8 image, default widths).
// Expected results come from a direct 3x3 convolution of each frame held in an array.
module tb_conv3x3_stream;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int NPIX = IW * IH;
  localparam int NOUT = (IW - 2) * (IH - 2);

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               pix_valid = 1'b0;
  logic        [7:0]  pix_data = '0;
  logic               coef_we = 1'b0;
  logic        [3:0]  coef_addr = '0;
  logic signed [7:0]  coef_data = '0;
  logic               out_valid;
  logic signed [20:0] out_data;
  logic               frame_done;

  conv3x3_stream #(
    .IMG_W  (IW),
    .IMG_H  (IH),
    .DATA_W (8),
    .COEF_W (8),
    .ACC_W  (21)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int cmp_n = 0;
  int fail_n = 0;
  int edge_n = 0;
  int img [NPIX];
  int kern [9];
  int acc_edge [NPIX];
  int got_val [$];
  int got_edge [$];
  int fd_n = 0;
  int fd_edge = -1;

  always @(posedge clock) edge_n++;

  always @(negedge clock) begin
    if (out_valid) begin
      got_val.push_back(int'(out_data));
      got_edge.push_back(edge_n);
    end
    if (frame_done) begin
      fd_n++;
      fd_edge = edge_n;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    cmp_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    got_val.delete();
    got_edge.delete();
    fd_n = 0;
    fd_edge = -1;
  endtask

  task automatic load_kernel();
    for (int t = 0; t < 9; t++) begin
      @(negedge clock);
      coef_we = 1'b1;
      coef_addr = 4'(t);
      coef_data = 8'(kern[t]);
    end
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random idle gaps
  task automatic drive_pixels(input int mode, input int n);
    for (int p = 0; p < n; p++) begin
      if (mode == 1 && p > 0) begin
        @(negedge clock);
        pix_valid = 1'b0;
      end
      if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clock);
          pix_valid = 1'b0;
        end
      end
      @(negedge clock);
      pix_valid = 1'b1;
      pix_data = 8'(img[p]);
      acc_edge[p] = edge_n + 1;
    end
    @(negedge clock);
    pix_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int exp_v [$];
    int exp_e [$];
    int s;
    for (int r = 2; r < IH; r++) begin
      for (int c = 2; c < IW; c++) begin
        s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += img[(r - 2 + dr) * IW + (c - 2 + dc)] * kern[dr * 3 + dc];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_v.push_back(s);
        exp_e.push_back(acc_edge[r * IW + c] + 2);
      end
    end
    chk($sformatf("%s.count", tag), got_val.size(), NOUT);
    for (int j = 0; j < NOUT && j < got_val.size(); j++) begin
      chk($sformatf("%s.val[%0d]", tag, j), got_val[j], exp_v[j]);
      chk($sformatf("%s.edge[%0d]", tag, j), got_edge[j], exp_e[j]);
    end
    chk($sformatf("%s.frame_done_count", tag), fd_n, 1);
    chk($sformatf("%s.frame_done_edge", tag), fd_edge, acc_edge[NPIX - 1]);
    clear_capture();
  endtask

  initial begin
    // reset state
    #1 reset = 1'b0;
    #2;
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.out_data", int'(out_data), 0);
    chk("reset.frame_done", int'(frame_done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // 1: identity kernel, ramp, back-to-back
    for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
    for (int p = 0; p < NPIX; p++) img[p] = p;
    load_kernel();
    drive_pixels(0, NPIX);
    repeat (6) @(negedge clock);
    chk("ident.first", (got_val.size() > 0) ? got_val[0] : -1, 9);
    check_frame("ident");

    // 2: all-ones kernel
    for (int t = 0; t < 9; t++) kern[t] = 1;
    load_kernel();
    drive_pixels(0, NPIX);
    repeat (6) @(negedge clock);
    chk("ones.first", (got_val.size() > 0) ? got_val[0] : -1, 81);
    chk("ones.last", (got_val.size() == NOUT) ? got_val[NOUT - 1] : -1, 486);
    check_frame("ones");

    // 3: coef[0] = -1, all pixels 255
    for (int t = 0; t < 9; t++) kern[t] = (t == 0) ? -1 : 0;
    for (int p = 0; p < NPIX; p++) img[p] = 255;
    load_kernel();
    drive_pixels(0, NPIX);
    repeat (6) @(negedge clock);
    check_frame("neg");

    // 4: identity, pix_valid toggling
    for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
    for (int p = 0; p < NPIX; p++) img[p] = p;
    load_kernel();
    drive_pixels(1, NPIX);
    repeat (6) @(negedge clock);
    check_frame("toggle");

    // 5: reset after 20 pixels, then a full frame
    drive_pixels(0, 20);
    @(negedge clock);
    chk("midreset.pre_out_valid", int'(out_valid), 1);
    #1 reset = 1'b0;
    #1;
    chk("midreset.out_valid", int'(out_valid), 0);
    chk("midreset.frame_done", int'(frame_done), 0);
    chk("midreset.out_data", int'(out_data), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_capture();
    load_kernel();
    drive_pixels(0, NPIX);
    repeat (6) @(negedge clock);
    check_frame("restart");

    // 6: write to an out-of-range tap address leaves the kernel untouched
    @(negedge clock);
    coef_we = 1'b1;
    coef_addr = 4'd12;
    coef_data = 8'sh55;
    @(negedge clock);
    coef_we = 1'b0;
    drive_pixels(0, NPIX);
    repeat (6) @(negedge clock);
    check_frame("badaddr");

    // random kernels and images, with and without idle gaps
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(0, 255)) - 128;
      for (int p = 0; p < NPIX; p++) img[p] = int'($urandom_range(0, 255));
      load_kernel();
      drive_pixels((f == 1) ? 0 : 2, NPIX);
      repeat (6) @(negedge clock);
      check_frame($sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
